ultrasound_time_cnt: RTL and testbench
======================================

ULTRASOUND_TIME_CNT -- requirements
Module: ultrasound_time_cnt

Interface
REQ-001 Parameter CYCLE_BITS, default 9, SHALL set log2 of ultrasound period in CLK ticks (512 ticks = 40 kHz at 20.48 MHz).
REQ-002 CLK  input  1  20.48 MHz ultrasound count clock; sole clock.
REQ-003 RESETN  input  1  asynchronous, active-low reset.
REQ-004 LOCKED  input  1  clock generator lock; level, synchronous to CLK.
REQ-005 SYS_TIME  input  64  system time; +1 per CLK when healthy.
REQ-006 MOD_DIV  input  16  ultrasound periods per modulation index step; 0 treated as 1.
REQ-007 CLR_STAT  input  1  one-cycle pulse; clears JUMP_CNT.
REQ-008 TIME_CNT  output  CYCLE_BITS  phase within ultrasound period.
REQ-009 UPDATE  output  1  one-cycle pulse at period start.
REQ-010 MOD_IDX  output  16  modulation sample index.
REQ-011 RUNNING  output  1  high in RUN state.
REQ-012 JUMP  output  1  one-cycle pulse on SYS_TIME discontinuity.
REQ-013 JUMP_CNT  output  16  discontinuity count (only with macro, REQ-027).

Function
REQ-014 FSM states WAIT_LOCK, ALIGN, RUN SHALL exist; reset state WAIT_LOCK.
REQ-015 WAIT_LOCK -> ALIGN when LOCKED=1; all outputs held at reset values.
REQ-016 ALIGN SHALL last one cycle: prev <= SYS_TIME, TIME_CNT <= SYS_TIME[CYCLE_BITS-1:0], MOD_IDX/div_cnt <= 0, then -> RUN.
REQ-017 RUN, SYS_TIME == prev+1 (64-bit wrap allowed): TIME_CNT <= SYS_TIME[CYCLE_BITS-1:0]; UPDATE <= 1 iff those bits are 0.
REQ-018 RUN, SYS_TIME != prev+1: JUMP <= 1, TIME_CNT <= SYS_TIME low bits, UPDATE <= 0, div_cnt and MOD_IDX <= 0; stay in RUN.
REQ-019 prev SHALL capture SYS_TIME every RUN cycle.
REQ-020 All outputs registered; latency one CLK from SYS_TIME sample to TIME_CNT/UPDATE/JUMP.
REQ-021 On each UPDATE: if div_cnt == div_lat-1 then div_cnt <= 0, MOD_IDX <= MOD_IDX+1 (16-bit wrap), div_lat <= max(MOD_DIV,1); else div_cnt++.
REQ-022 div_lat SHALL load max(MOD_DIV,1) in ALIGN; MOD_DIV changes take effect only at a modulation step boundary.
REQ-023 LOCKED=0 in any state SHALL force WAIT_LOCK next cycle; outputs except JUMP_CNT cleared.
REQ-024 JUMP_CNT saturates at 0xFFFF; CLR_STAT coincident with jump SHALL yield JUMP_CNT=1.

Reset
REQ-025 On RESETN=0: state WAIT_LOCK; TIME_CNT, UPDATE, MOD_IDX, RUNNING, JUMP, JUMP_CNT, prev, div_cnt = 0; div_lat = 1.
REQ-026 Reset mid-period SHALL discard all phase; realignment only via ALIGN.

Configuration
REQ-027 Macro ULTRASOUND_JUMP_STAT_EN defined: JUMP_CNT and CLR_STAT logic present; undefined: JUMP_CNT tied 0, CLR_STAT ignored, JUMP pulse still produced.

Structure
REQ-028 Package ultrasound_time_pkg SHALL hold FSM state enum, default CYCLE_BITS constant, MOD_DIV/MOD_IDX widths.
REQ-029 One sub-module mod_idx_divider SHALL implement REQ-021/022 (div_cnt, div_lat, MOD_IDX).

Verification
REQ-030 Reset, LOCKED=1 at 1 us, SYS_TIME from 1 -> first UPDATE one cycle after SYS_TIME=512; TIME_CNT tracks SYS_TIME mod 512.
REQ-031 MOD_DIV=4 -> MOD_IDX increments every 2048 CLK; MOD_DIV=0 -> every 512 CLK.
REQ-032 SYS_TIME jumps 1000 -> 5000 -> JUMP one cycle, TIME_CNT=392 (5000 mod 512), MOD_IDX=0, JUMP_CNT=1.
REQ-033 LOCKED drops for 3 cycles in RUN -> RUNNING=0, outputs 0 next cycle; re-lock -> ALIGN then RUN, no JUMP.
REQ-034 SYS_TIME 0xFFFF_FFFF_FFFF_FFFF -> 0 -> no JUMP, UPDATE asserted.
REQ-035 Build without ULTRASOUND_JUMP_STAT_EN, repeat REQ-032 -> JUMP pulses, JUMP_CNT stays 0.

Source files
------------

// File: rtl/ultrasound_time_pkg.sv
// Shared types and constants for the ultrasound time counter.
// ULTRASOUND_JUMP_STAT_EN enables the JUMP_CNT statistics counter.
package ultrasound_time_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    ALIGN     = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int CYCLE_BITS_DEF = 9;
  localparam int MOD_DIV_W      = 16;
  localparam int MOD_IDX_W      = 16;

  function automatic logic [MOD_DIV_W-1:0] div_floor1(
    input logic [MOD_DIV_W-1:0] d
  );
    return (d == '0) ? MOD_DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/ultrasound_time_cnt_mod_idx_divider.sv
// Divides ultrasound period starts down to modulation index steps.
// A new divider ratio is only adopted on a step boundary.
import ultrasound_time_pkg::*;

module mod_idx_divider (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_i,
  input  logic                 clr_i,
  input  logic                 step_i,
  input  logic [MOD_DIV_W-1:0] mod_div_i,
  output logic [MOD_IDX_W-1:0] mod_idx_o
);

  logic [MOD_DIV_W-1:0] cnt_q;
  logic [MOD_DIV_W-1:0] lat_q;
  logic [MOD_IDX_W-1:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lat_q <= MOD_DIV_W'(1);
      idx_q <= '0;
    end else if (init_i) begin
      cnt_q <= '0;
      lat_q <= div_floor1(mod_div_i);
      idx_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (step_i) begin
      if (cnt_q == lat_q - MOD_DIV_W'(1)) begin
        cnt_q <= '0;
        idx_q <= idx_q + MOD_IDX_W'(1);
        lat_q <= div_floor1(mod_div_i);
      end else begin
        cnt_q <= cnt_q + MOD_DIV_W'(1);
      end
    end
  end

  assign mod_idx_o = idx_q;

endmodule

// File: rtl/ultrasound_time_cnt.sv
// Ultrasound phase counter locked to system time, with jump detection.
// ULTRASOUND_JUMP_STAT_EN adds the saturating JUMP_CNT statistic.
import ultrasound_time_pkg::*;

module ultrasound_time_cnt #(
  parameter int CYCLE_BITS = CYCLE_BITS_DEF
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  LOCKED,
  input  logic [63:0]           SYS_TIME,
  input  logic [MOD_DIV_W-1:0]  MOD_DIV,
  input  logic                  CLR_STAT,
  output logic [CYCLE_BITS-1:0] TIME_CNT,
  output logic                  UPDATE,
  output logic [MOD_IDX_W-1:0]  MOD_IDX,
  output logic                  RUNNING,
  output logic                  JUMP,
  output logic [15:0]           JUMP_CNT
);

  state_e                state_q;
  logic [63:0]           prev_q;
  logic [CYCLE_BITS-1:0] tcnt_q;
  logic                  upd_q;
  logic                  run_q;
  logic                  jump_q;

  logic [CYCLE_BITS-1:0] low;
  logic                  seq_ok;
  logic                  in_run;
  logic                  jump_ev;
  logic                  step;
  logic                  init;
  logic                  clr;

  always_comb begin
    low     = SYS_TIME[CYCLE_BITS-1:0];
    seq_ok  = (SYS_TIME == prev_q + 64'd1);
    in_run  = (state_q == RUN) && LOCKED;
    jump_ev = in_run && !seq_ok;
    step    = in_run && seq_ok && (low == '0);
    init    = (state_q == ALIGN) && LOCKED;
    clr     = !LOCKED || jump_ev;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= WAIT_LOCK;
      prev_q  <= '0;
      tcnt_q  <= '0;
      upd_q   <= 1'b0;
      run_q   <= 1'b0;
      jump_q  <= 1'b0;
    end else if (!LOCKED) begin
      state_q <= WAIT_LOCK;
      prev_q  <= '0;
      tcnt_q  <= '0;
      upd_q   <= 1'b0;
      run_q   <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          state_q <= ALIGN;
          tcnt_q  <= '0;
          upd_q   <= 1'b0;
          run_q   <= 1'b0;
          jump_q  <= 1'b0;
        end
        ALIGN: begin
          state_q <= RUN;
          prev_q  <= SYS_TIME;
          tcnt_q  <= low;
          upd_q   <= 1'b0;
          run_q   <= 1'b1;
          jump_q  <= 1'b0;
        end
        RUN: begin
          prev_q  <= SYS_TIME;
          tcnt_q  <= low;
          upd_q   <= step;
          run_q   <= 1'b1;
          jump_q  <= jump_ev;
        end
        default: begin
          state_q <= WAIT_LOCK;
        end
      endcase
    end
  end

  mod_idx_divider u_div (
    .clk       (CLK),
    .rst_n     (RESETN),
    .init_i    (init),
    .clr_i     (clr),
    .step_i    (step),
    .mod_div_i (MOD_DIV),
    .mod_idx_o (MOD_IDX)
  );

  assign TIME_CNT = tcnt_q;
  assign UPDATE   = upd_q;
  assign RUNNING  = run_q;
  assign JUMP     = jump_q;

`ifdef ULTRASOUND_JUMP_STAT_EN
  logic [15:0] jcnt_q;

  // Survives loss of lock; only reset or CLR_STAT clears it.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      jcnt_q <= '0;
    end else if (jump_ev) begin
      if (CLR_STAT) begin
        jcnt_q <= 16'd1;
      end else if (jcnt_q != 16'hFFFF) begin
        jcnt_q <= jcnt_q + 16'd1;
      end
    end else if (CLR_STAT) begin
      jcnt_q <= '0;
    end
  end

  assign JUMP_CNT = jcnt_q;
`else
  logic unused_clr;
  assign unused_clr = CLR_STAT;
  assign JUMP_CNT   = '0;
`endif

endmodule

// File: tb/tb_ultrasound_time_cnt.sv
// Scoreboard bench for ultrasound_time_cnt against a cycle-level reference.
module tb_ultrasound_time_cnt;

`ifdef ULTRASOUND_JUMP_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        locked = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] sys = '0;
  logic [15:0] md = '0;

  logic [8:0]  TIME_CNT;
  logic        UPDATE;
  logic [15:0] MOD_IDX;
  logic        RUNNING;
  logic        JUMP;
  logic [15:0] JUMP_CNT;

  ultrasound_time_cnt #(.CYCLE_BITS(9)) dut (
    .CLK      (clk),
    .RESETN   (rstn),
    .LOCKED   (locked),
    .SYS_TIME (sys),
    .MOD_DIV  (md),
    .CLR_STAT (clr),
    .TIME_CNT (TIME_CNT),
    .UPDATE   (UPDATE),
    .MOD_IDX  (MOD_IDX),
    .RUNNING  (RUNNING),
    .JUMP     (JUMP),
    .JUMP_CNT (JUMP_CNT)
  );

  always #24 clk = ~clk;

  typedef struct packed {
    logic [8:0]  tc;
    logic        upd;
    logic [15:0] idx;
    logic        run;
    logic        jmp;
    logic [15:0] jc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference: 0 = waiting for lock, 1 = aligning, 2 = running.
  int          mst = 0;
  logic [63:0] mprev = '0;
  int unsigned mlat = 1;
  int unsigned mupd = 0;
  logic [15:0] midx = '0;
  logic [15:0] mjc = '0;
  exp_t        mo = '0;

  task automatic model_edge();
    bit jumped = 1'b0;
    if (!rstn) begin
      mst = 0; mprev = '0; mlat = 1; mupd = 0;
      midx = '0; mjc = '0; mo = '0;
    end else begin
      if (!locked) begin
        mst = 0; mprev = '0; mupd = 0; midx = '0;
        mo.tc = '0; mo.upd = 0; mo.run = 0; mo.jmp = 0;
      end else if (mst == 0) begin
        mst = 1;
        mo.tc = '0; mo.upd = 0; mo.run = 0; mo.jmp = 0;
      end else if (mst == 1) begin
        mst = 2;
        mprev = sys; mupd = 0; midx = '0;
        mlat = (md == 0) ? 1 : int'(md);
        mo.tc = 9'(sys % 64'd512);
        mo.upd = 0; mo.run = 1; mo.jmp = 0;
      end else begin
        mo.tc = 9'(sys % 64'd512);
        mo.run = 1;
        if (sys == 64'(mprev + 64'd1)) begin
          mo.jmp = 0;
          mo.upd = (sys % 64'd512) == 0;
          if (mo.upd) begin
            mupd++;
            if (mupd >= mlat) begin
              mupd = 0;
              midx = midx + 16'd1;
              mlat = (md == 0) ? 1 : int'(md);
            end
          end
        end else begin
          jumped = 1'b1;
          mo.jmp = 1; mo.upd = 0;
          mupd = 0; midx = '0;
        end
        mprev = sys;
      end
      if (STAT) begin
        if (jumped) mjc = clr ? 16'd1 : ((mjc == 16'hFFFF) ? mjc : mjc + 16'd1);
        else if (clr) mjc = '0;
      end else begin
        mjc = '0;
      end
      mo.idx = midx;
      mo.jc = mjc;
    end
    q.push_back(mo);
  endtask

  task automatic cyc(input logic lk, input logic [63:0] t,
                     input logic [15:0] d, input logic c);
    locked = lk; sys = t; md = d; clr = c;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic run(input int n, input logic [15:0] d);
    repeat (n) cyc(1'b1, sys + 64'd1, d, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        g = {TIME_CNT, UPDATE, MOD_IDX, RUNNING, JUMP, JUMP_CNT};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL sb t=%0t got tc=%0d u=%0b i=%0d r=%0b j=%0b c=%0d exp tc=%0d u=%0b i=%0d r=%0b j=%0b c=%0d",
                   $time, g.tc, g.upd, g.idx, g.run, g.jmp, g.jc,
                   e.tc, e.upd, e.idx, e.run, e.jmp, e.jc);
        end
      end
    end
  end

  initial begin : driver
    int unsigned r;
    logic c;
    repeat (4) cyc(1'b0, 64'd0, 16'd0, 1'b0);
    chk("rst_tc", 64'(TIME_CNT), 0);
    chk("rst_upd", 64'(UPDATE), 0);
    chk("rst_idx", 64'(MOD_IDX), 0);
    chk("rst_run", 64'(RUNNING), 0);
    chk("rst_jmp", 64'(JUMP), 0);
    chk("rst_jc", 64'(JUMP_CNT), 0);
    rstn = 1'b1;
    repeat (16) cyc(1'b0, 64'd0, 16'd0, 1'b0);

    while (sys < 64'd512) cyc(1'b1, sys + 64'd1, 16'd4, 1'b0);
    chk("first_upd", 64'(UPDATE), 1);
    chk("first_tc", 64'(TIME_CNT), 0);
    chk("first_run", 64'(RUNNING), 1);
    while (sys < 64'd2048) cyc(1'b1, sys + 64'd1, 16'd4, 1'b0);
    chk("div4_idx", 64'(MOD_IDX), 1);
    while (sys < 64'd4608) cyc(1'b1, sys + 64'd1, 16'd0, 1'b0);
    chk("div0_idx", 64'(MOD_IDX), 3);

    cyc(1'b1, 64'd1000, 16'd0, 1'b1);
    cyc(1'b1, 64'd1001, 16'd0, 1'b1);
    cyc(1'b1, 64'd5000, 16'd0, 1'b0);
    chk("jmp_pulse", 64'(JUMP), 1);
    chk("jmp_tc", 64'(TIME_CNT), 392);
    chk("jmp_idx", 64'(MOD_IDX), 0);
    chk("jmp_cnt", 64'(JUMP_CNT), STAT ? 64'd1 : 64'd0);
    run(1, 16'd0);
    chk("jmp_once", 64'(JUMP), 0);

    run(50, 16'd2);
    cyc(1'b0, sys + 64'd1, 16'd2, 1'b0);
    chk("unlock_run", 64'(RUNNING), 0);
    chk("unlock_tc", 64'(TIME_CNT), 0);
    repeat (2) cyc(1'b0, sys + 64'd1, 16'd2, 1'b0);
    run(3, 16'd2);
    chk("relock_run", 64'(RUNNING), 1);
    chk("relock_jmp", 64'(JUMP), 0);
    run(600, 16'd2);

    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 16'd1, 1'b0);
    run(15, 16'd1);
    cyc(1'b1, 64'd0, 16'd1, 1'b0);
    chk("wrap_jmp", 64'(JUMP), 0);
    chk("wrap_upd", 64'(UPDATE), 1);

    for (int i = 0; i < 6000; i++) begin
      r = $urandom_range(0, 999);
      c = ($urandom_range(0, 49) == 0);
      if (r < 5) begin
        cyc(1'b1, {$urandom, $urandom}, md, c);
      end else if (r < 9) begin
        repeat ($urandom_range(1, 3)) cyc(1'b0, sys + 64'd1, md, c);
      end else if (r < 14) begin
        cyc(1'b1, sys + 64'd1, 16'($urandom_range(0, 3)), c);
      end else begin
        cyc(1'b1, sys + 64'd1, md, c);
      end
    end

    @(negedge clk);
    #1;
    chk("sb_drain", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
